// File: rtl/fix_fft_reorder.sv
// Ping-pong frame buffer that reorders FFT output frames from bit-reversed to natural
// bin order (or passes them through), with valid/ready on both sides.
module fix_fft_reorder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG2N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rev_en,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_i,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_r,
  output logic [WIDTH-1:0] out_i,
  output logic             out_sof,
  output logic             out_eof,
  output logic [LOG2N-1:0] out_idx
);

  localparam int unsigned N = 2 ** LOG2N;

  // Bank select is the top address bit: entries [0, N) are bank 0, [N, 2N) are bank 1.
  logic [2*WIDTH-1:0] mem [2*N];

  logic             wb, rb;
  logic [LOG2N-1:0] wr_cnt, rd_cnt;
  logic [1:0]       full, full_d, mode;
  logic             wr_en, rd_en, adv;
  logic             wr_last, rd_last;
  logic [LOG2N-1:0] rd_addr;
  logic [2*WIDTH-1:0] rd_data;

  assign in_rdy  = ~full[wb];
  assign wr_en   = in_vld & in_rdy;
  assign adv     = ~out_vld | out_rdy;
  assign rd_en   = adv & full[rb];
  assign wr_last = (wr_cnt == '1);
  assign rd_last = (rd_cnt == '1);

  always_comb begin
    rd_addr = rd_cnt;
    if (mode[rb]) begin
      for (int i = 0; i < LOG2N; i++) begin
        rd_addr[i] = rd_cnt[LOG2N-1-i];
      end
    end
  end

  assign rd_data = mem[{rb, rd_addr}];

  // Write and release always target different banks, so both updates can land together.
  always_comb begin
    full_d = full;
    if (wr_en && wr_last) full_d[wb] = 1'b1;
    if (rd_en && rd_last) full_d[rb] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wb, wr_cnt}] <= {in_r, in_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb     <= 1'b0;
      wr_cnt <= '0;
      mode   <= 2'b00;
      full   <= 2'b00;
    end else begin
      full <= full_d;
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == '0) mode[wb] <= rev_en;
        if (wr_last) wb <= ~wb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb      <= 1'b0;
      rd_cnt  <= '0;
      out_vld <= 1'b0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      out_idx <= '0;
      out_r   <= '0;
      out_i   <= '0;
    end else if (rd_en) begin
      {out_r, out_i} <= rd_data;
      out_idx <= rd_cnt;
      out_sof <= (rd_cnt == '0);
      out_eof <= rd_last;
      out_vld <= 1'b1;
      rd_cnt  <= rd_cnt + 1'b1;
      if (rd_last) rb <= ~rb;
    end else if (adv) begin
      out_vld <= 1'b0;
    end
  end

endmodule
